// File: rtl/tc_pkg.sv
// Shared definitions for tc_timer: register map, CTRL bit positions, mode codes and FSM states.
// The system bridge reuses TcBaseAddr and the Off* byte offsets for its address decode.
package tc_pkg;

  localparam logic [31:0] TcBaseAddr    = 32'h0000_7F00;
  localparam logic [31:0] TcWindowBytes = 32'd12;

  localparam logic [31:0] OffCtrl   = 32'h0;
  localparam logic [31:0] OffPreset = 32'h4;
  localparam logic [31:0] OffCount  = 32'h8;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlModeLsb = 1;
  localparam int unsigned CtrlImBit   = 3;
  localparam int unsigned CtrlWidth   = 4;

  typedef enum logic [1:0] {
    ModeOneShot    = 2'd0,
    ModeAutoReload = 2'd1,
    ModeRsvd2      = 2'd2,
    ModeRsvd3      = 2'd3
  } tc_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } tc_state_e;

  function automatic logic [31:0] apply_byteen(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tc_prescale.sv
// Count-tick generator for tc_timer: one tick every PRESCALE cycles while run is high.
module tc_prescale
  import tc_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastDiv = CntW'(PRESCALE - 1);

  logic [CntW-1:0] div_q, div_d;

  assign tick = run && (div_q == LastDiv);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (run) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/tc_timer.sv
// Memory-mapped timer/counter (CTRL/PRESET/COUNT) with a single interrupt line.
// Define TC_PRESCALE_EN to gate count ticks through a PRESCALE-cycle divider.
module tc_timer
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TcBaseAddr,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [31:0]          offset;
  logic [1:0]           word_sel;
  logic                 wr_ctrl, wr_preset;
  logic                 tick;
  logic                 en;
  logic [1:0]           mode;

  logic [CtrlWidth-1:0] ctrl_q, ctrl_d;
  logic [31:0]          preset_q, preset_d;
  logic [31:0]          count_q, count_d;
  logic                 irq_flag_q, irq_flag_d;
  tc_state_e            state_q, state_d;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  assign offset    = addr - BASE_ADDR;
  assign hit       = offset < TcWindowBytes;
  assign word_sel  = offset[3:2];
  assign wr_ctrl   = we && hit && (word_sel == OffCtrl[3:2]);
  assign wr_preset = we && hit && (word_sel == OffPreset[3:2]);

  assign en   = ctrl_q[CtrlEnBit];
  assign mode = ctrl_q[CtrlModeLsb +: 2];
  assign irq  = ctrl_q[CtrlImBit] & irq_flag_q;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (word_sel)
        OffCtrl[3:2]:   rdata = 32'(ctrl_q);
        OffPreset[3:2]: rdata = preset_q;
        OffCount[3:2]:  rdata = count_q;
        default:        rdata = '0;
      endcase
    end
  end

`ifdef TC_PRESCALE_EN
  logic presc_clear, presc_run;

  assign presc_clear = wr_ctrl || (state_q == StLoad);
  assign presc_run   = (state_q == StCnt);

  tc_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (tick)
  );
`else
  logic unused_prescale;

  assign unused_prescale = ^PRESCALE;
  assign tick            = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (wr_ctrl) begin
      // A control write restarts the FSM and discards whatever it would have done this cycle.
      if (byteen[0]) ctrl_d = wdata[CtrlWidth-1:0];
      state_d    = StIdle;
      irq_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) state_d = StLoad;
        end
        StLoad: begin
          count_d = preset_q;
          state_d = StCnt;
        end
        StCnt: begin
          if (!en) begin
            state_d = StIdle;
          end else if (tick) begin
            if (count_q <= 32'd1) begin
              count_d    = '0;
              state_d    = StInt;
              irq_flag_d = 1'b1;
            end else begin
              count_d = count_q - 32'd1;
            end
          end
        end
        StInt: begin
          if (mode == ModeAutoReload) begin
            state_d    = StLoad;
            irq_flag_d = 1'b0;
          end else begin
            ctrl_d[CtrlEnBit] = 1'b0;
            state_d           = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (wr_preset) begin
        preset_d   = apply_byteen(preset_q, wdata, byteen);
        irq_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule

// File: tb/tb_tc_timer.sv
// Bench for tc_timer: directed scenarios with fixed expectations, then random bus traffic
// checked against a behavioural model of the register/timer rules.
`timescale 1ns/1ps
module tb_tc_timer;

  localparam logic [31:0] Base = 32'h0000_7F00;
  localparam int PhIdle = 0, PhLoad = 1, PhCnt = 2, PhInt = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = Base;
  logic [31:0] wdata = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] rdata;
  logic        hit, irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_ctrl, m_preset, m_count;
  logic        m_flag;
  int          m_phase;

  tc_timer dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= Base) && (a < Base + 32'd12);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case ((a - Base) >> 2)
      0:       return m_ctrl;
      1:       return m_preset;
      default: return m_count;
    endcase
  endfunction

  // Applies the effect of the coming clock edge to the model, using the current bus inputs.
  task automatic model_edge();
    logic        wr;
    logic [31:0] off, mask;
    if (reset) begin
      m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = PhIdle;
      return;
    end
    wr   = we && m_hit(addr);
    off  = addr - Base;
    mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    if (wr && off < 4) begin
      m_ctrl  = ((m_ctrl & ~mask) | (wdata & mask)) & 32'hF;
      m_phase = PhIdle;
      m_flag  = 0;
      return;
    end
    case (m_phase)
      PhIdle: if (m_ctrl[0]) m_phase = PhLoad;
      PhLoad: begin m_count = m_preset; m_phase = PhCnt; end
      PhCnt: begin
        if (!m_ctrl[0]) m_phase = PhIdle;
        else if (m_count <= 1) begin m_count = 0; m_phase = PhInt; m_flag = 1; end
        else m_count = m_count - 1;
      end
      default: begin
        if (m_ctrl[2:1] == 2'd1) begin m_phase = PhLoad; m_flag = 0; end
        else begin m_ctrl[0] = 1'b0; m_phase = PhIdle; end
      end
    endcase
    if (wr && off >= 4 && off < 8) begin
      m_preset = (m_preset & ~mask) | (wdata & mask);
      m_flag   = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byteen = be; we = 1'b1;
    tick();
    we = 1'b0; byteen = 4'h0;
  endtask

  task automatic do_reset();
    we = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr = Base + 32'(4 * i); #1;
      n_vec++;
      if (rdata !== 32'h0) begin
        n_err++; $display("FAIL reset_rdata[%0d]: got %h expected 00000000", i, rdata);
      end
      n_vec++;
      if (hit !== 1'b1) begin n_err++; $display("FAIL reset_hit[%0d]: got %b expected 1", i, hit); end
    end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    addr = Base + 32'hC; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL hit_0xC: got %b expected 0", hit); end
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL rdata_0xC: got %h expected 0", rdata); end
    addr = Base - 32'h4; #1;
    n_vec++;
    if (hit !== 1'b0) begin n_err++; $display("FAIL hit_below: got %b expected 0", hit); end
  endtask

  task automatic test_oneshot();
    int exp_cnt[6] = '{0, 3, 2, 1, 0, 0};
    int exp_irq[6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    wr(Base + 32'h4, 32'd3, 4'hF);
    wr(Base, 32'h9, 4'hF);
    addr = Base + 32'h8;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (rdata !== 32'(exp_cnt[i])) begin
        n_err++; $display("FAIL oneshot_count T%0d: got %0d expected %0d", i + 1, rdata, exp_cnt[i]);
      end
      n_vec++;
      if (irq !== (exp_irq[i] != 0)) begin
        n_err++; $display("FAIL oneshot_irq T%0d: got %b expected %0d", i + 1, irq, exp_irq[i]);
      end
    end
    addr = Base; #1;
    n_vec++;
    if (rdata !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl: got %h expected 8", rdata); end
    tick();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL oneshot_irq_hold: got %b expected 1", irq); end
    wr(Base + 32'h4, 32'd3, 4'hF);
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_clr: got %b expected 0", irq); end
  endtask

  task automatic test_autoreload();
    int pat[4] = '{2, 1, 0, 0};
    int exp_c;
    do_reset();
    wr(Base + 32'h4, 32'd2, 4'hF);
    wr(Base, 32'hB, 4'hF);
    addr = Base + 32'h8;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_c = (i < 2) ? 0 : pat[(i - 2) % 4];
      n_vec++;
      if (rdata !== 32'(exp_c)) begin
        n_err++; $display("FAIL reload_count T%0d: got %0d expected %0d", i, rdata, exp_c);
      end
      n_vec++;
      if (irq !== (i % 4 == 0)) begin
        n_err++; $display("FAIL reload_irq T%0d: got %b expected %b", i, irq, (i % 4 == 0));
      end
    end
  endtask

  task automatic test_byteen();
    do_reset();
    wr(Base + 32'h4, 32'hAABB_CCDD, 4'b0010);
    addr = Base + 32'h4; #1;
    n_vec++;
    if (rdata !== 32'h0000_CC00) begin
      n_err++; $display("FAIL be_preset1: got %h expected 0000cc00", rdata);
    end
    wr(Base + 32'h6, 32'h1122_3344, 4'b1001);
    addr = Base + 32'h4; #1;
    n_vec++;
    if (rdata !== 32'h1100_CC44) begin
      n_err++; $display("FAIL be_preset2: got %h expected 1100cc44", rdata);
    end
    wr(Base + 32'hC, 32'h5, 4'hF);
    wr(Base - 32'h4, 32'h5, 4'hF);
    addr = Base + 32'h4; #1;
    n_vec++;
    if (rdata !== 32'h1100_CC44) begin
      n_err++; $display("FAIL outside_write: got %h expected 1100cc44", rdata);
    end
    wr(Base + 32'h8, 32'h1234, 4'hF);
    addr = Base + 32'h8; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL count_ro: got %h expected 0", rdata); end
    wr(Base, 32'hFFFF_FFFF, 4'b0001);
    addr = Base; #1;
    n_vec++;
    if (rdata !== 32'hF) begin n_err++; $display("FAIL ctrl_mask: got %h expected f", rdata); end
    wr(Base, 32'h0000_0000, 4'b1110);
    addr = Base; #1;
    n_vec++;
    if (rdata !== 32'hF) begin n_err++; $display("FAIL ctrl_be: got %h expected f", rdata); end
  endtask

  task automatic test_midcount_stop();
    do_reset();
    wr(Base + 32'h4, 32'd10, 4'hF);
    wr(Base, 32'h9, 4'hF);
    addr = Base + 32'h8;
    repeat (7) tick();
    n_vec++;
    if (rdata !== 32'd5) begin n_err++; $display("FAIL stop_pre: got %0d expected 5", rdata); end
    wr(Base, 32'h0, 4'hF);
    addr = Base + 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (rdata !== 32'd5 || irq !== 1'b0) begin
        n_err++; $display("FAIL stop_hold[%0d]: got count %0d irq %b expected 5 0", i, rdata, irq);
      end
      tick();
    end
  endtask

  task automatic test_im_masked();
    do_reset();
    wr(Base + 32'h4, 32'd1, 4'hF);
    wr(Base, 32'h1, 4'hF);
    addr = Base + 32'h8;
    repeat (3) tick();
    n_vec++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin
      n_err++; $display("FAIL masked_expiry: got count %0d irq %b expected 0 0", rdata, irq);
    end
    tick();
    addr = Base; #1;
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL masked_en_clr: got %h expected 0", rdata); end
    wr(Base, 32'h8, 4'hF);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL masked_im_on[%0d]: got %b expected 0", i, irq); end
      tick();
    end
  endtask

  task automatic test_boundary();
    do_reset();
    wr(Base, 32'h9, 4'hF);
    addr = Base + 32'h8;
    tick(); tick();
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL preset0_early: got %b expected 0", irq); end
    tick();
    n_vec++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL preset0_irq: got %b expected 1", irq); end
    do_reset();
    wr(Base + 32'h4, 32'hFFFF_FFFF, 4'hF);
    wr(Base, 32'h1, 4'hF);
    addr = Base + 32'h8;
    tick(); tick();
    n_vec++;
    if (rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL max_load: got %h expected ffffffff", rdata); end
    tick();
    n_vec++;
    if (rdata !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL max_dec: got %h expected fffffffe", rdata); end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    wr(Base + 32'h4, 32'd20, 4'hF);
    wr(Base, 32'hB, 4'hF);
    addr = Base + 32'h8;
    repeat (5) tick();
    n_vec++;
    if (rdata !== 32'd17) begin n_err++; $display("FAIL rst_mid_pre: got %0d expected 17", rdata); end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addr = Base + 32'(4 * i); #1;
      n_vec++;
      if (rdata !== 32'h0 || irq !== 1'b0) begin
        n_err++; $display("FAIL rst_mid[%0d]: got rdata %h irq %b expected 0 0", i, rdata, irq);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 59);
      we = 1'b0; reset = 1'b0;
      byteen = 4'($urandom);
      wdata = $urandom;
      addr = ($urandom_range(0, 7) == 0) ? $urandom : Base + 32'($urandom_range(0, 15));
      if (r < 3) begin
        addr = Base + 32'($urandom_range(0, 3));
        if (r < 2) begin wdata[0] = 1'b1; byteen = 4'h1; end
        we = 1'b1;
      end else if (r < 6) begin
        addr = Base + 32'h4 + 32'($urandom_range(0, 3));
        wdata = (r == 5) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6));
        byteen = (r == 4) ? 4'($urandom) : 4'hF;
        we = 1'b1;
      end else if (r == 6) begin
        addr = Base + 32'h8;
        we = 1'b1;
      end else if (r == 7) begin
        we = 1'b1;
      end else if (r == 59) begin
        reset = 1'b1;
      end
      #1;
      n_vec++;
      if (hit !== m_hit(addr) || rdata !== m_read(addr) || irq !== (m_ctrl[3] & m_flag)) begin
        n_err++;
        $display("FAIL rand[%0d] addr %h: got hit %b rdata %h irq %b expected %b %h %b", i, addr,
                 hit, rdata, irq, m_hit(addr), m_read(addr), m_ctrl[3] & m_flag);
      end
      tick();
    end
    we = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byteen();
    test_midcount_stop();
    test_im_masked();
    test_boundary();
    test_reset_midcount();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
